// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit counter width: max(1, clog2(width)).
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Parallel-in/parallel-out handshake bundle for the serial adder controller.
// The master drives start and the operands; the slave returns busy/done and the result.
import serial_add_pkg::*;

interface serial_add_ctrl_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// Pure combinational one-bit full adder, shared by the serial controller
// and the combinational ripple adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures operands on start, adds one bit per
// cycle LSB-first through a single full adder, and publishes sum/cout with a done pulse.
import serial_add_pkg::*;

module serial_add_ctrl #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-2:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
    logic [WIDTH-1:0] psum_full;

    full_adder_bit u_fa (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    // The newest sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign psum_full = {fa_s, psum_q};

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    psum_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                psum_d  = psum_full[WIDTH-1:1];
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                carry_d = fa_co;
                if (last_bit) begin
                    // Counter holds on the final bit so it never wraps.
                    sum_d   = psum_full;
                    cout_d  = fa_co;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=3 and WIDTH=8.
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_add_ctrl_if #(.WIDTH(3)) bus3 ();
    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();

    serial_add_ctrl #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus3.start = 1'b0; bus3.a = '0; bus3.b = '0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        #3;
        checks++;
        if (bus3.busy !== 1'b0 || bus3.done !== 1'b0 || bus3.sum !== 3'b000 || bus3.cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_w3 busy=%b done=%b sum=%b cout=%b required 0/0/000/0",
                     bus3.busy, bus3.done, bus3.sum, bus3.cout);
        end
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_w8 busy=%b done=%b sum=%h cout=%b required 0/0/00/0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout);
        end
        tick();
        tick();
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        bus3.start = 1'b1; bus3.a = 3'b011; bus3.b = 3'b101;
        tick();
        bus3.start = 1'b0; bus3.a = 3'b000; bus3.b = 3'b000;
        for (int j = 0; j <= 4; j++) begin
            checks++;
            if (bus3.busy !== (j < 4) || bus3.done !== (j == 3)) begin
                failures++;
                $display("FAIL basic_hs j=%0d busy=%b done=%b required busy=%b done=%b",
                         j, bus3.busy, bus3.done, (j < 4), (j == 3));
            end
            if (j == 3) begin
                checks++;
                if (bus3.sum !== 3'b000 || bus3.cout !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_result sum=%b cout=%b required 000/1", bus3.sum, bus3.cout);
                end
                $display("op 011+101 sum=%b cout=%b", bus3.sum, bus3.cout);
            end
            if (j < 4) tick();
        end
    endtask

    task automatic test_sequential();
        logic [2:0] va [3];
        logic [2:0] vb [3];
        logic [2:0] vs [3];
        logic       vc [3];
        logic [2:0] prev_s;
        logic       prev_c;
        va[0] = 3'b111; vb[0] = 3'b111; vs[0] = 3'b110; vc[0] = 1'b1;
        va[1] = 3'b010; vb[1] = 3'b100; vs[1] = 3'b110; vc[1] = 1'b0;
        va[2] = 3'b001; vb[2] = 3'b001; vs[2] = 3'b010; vc[2] = 1'b0;
        prev_s = 3'b000; prev_c = 1'b1;
        for (int n = 0; n < 3; n++) begin
            bus3.start = 1'b1; bus3.a = va[n]; bus3.b = vb[n];
            tick();
            bus3.start = 1'b0; bus3.a = ~va[n]; bus3.b = ~vb[n];
            for (int j = 0; j <= 4; j++) begin
                checks++;
                if (bus3.busy !== (j < 4) || bus3.done !== (j == 3)) begin
                    failures++;
                    $display("FAIL seq%0d_hs j=%0d busy=%b done=%b required busy=%b done=%b",
                             n, j, bus3.busy, bus3.done, (j < 4), (j == 3));
                end
                checks++;
                if (j < 3 && (bus3.sum !== prev_s || bus3.cout !== prev_c)) begin
                    failures++;
                    $display("FAIL seq%0d_hold j=%0d sum=%b cout=%b required %b/%b",
                             n, j, bus3.sum, bus3.cout, prev_s, prev_c);
                end else if (j >= 3 && (bus3.sum !== vs[n] || bus3.cout !== vc[n])) begin
                    failures++;
                    $display("FAIL seq%0d_result j=%0d sum=%b cout=%b required %b/%b",
                             n, j, bus3.sum, bus3.cout, vs[n], vc[n]);
                end
                if (j < 4) tick();
            end
            $display("op %b+%b sum=%b cout=%b", va[n], vb[n], bus3.sum, bus3.cout);
            prev_s = vs[n];
            prev_c = vc[n];
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        done_cnt = 0;
        bus3.start = 1'b1; bus3.a = 3'b011; bus3.b = 3'b101;
        tick();
        bus3.start = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            checks++;
            if (bus3.busy !== (j < 4) || bus3.done !== (j == 3)) begin
                failures++;
                $display("FAIL ignore_hs j=%0d busy=%b done=%b required busy=%b done=%b",
                         j, bus3.busy, bus3.done, (j < 4), (j == 3));
            end
            if (bus3.done === 1'b1) done_cnt++;
            if (j == 1) begin
                checks++;
                if (bus3.sum !== 3'b010 || bus3.cout !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_hold sum=%b cout=%b required 010/0", bus3.sum, bus3.cout);
                end
            end
            case (j)
                1: begin bus3.start = 1'b1; bus3.a = 3'b111; bus3.b = 3'b111; end
                2: begin bus3.start = 1'b0; bus3.a = 3'b110; bus3.b = 3'b010; end
                3: bus3.start = 1'b1;
                4: bus3.start = 1'b0;
                default: ;
            endcase
            if (j < 6) tick();
        end
        checks++;
        if (done_cnt != 1 || bus3.sum !== 3'b000 || bus3.cout !== 1'b1) begin
            failures++;
            $display("FAIL ignore_result dones=%0d sum=%b cout=%b required 1 done, 000/1",
                     done_cnt, bus3.sum, bus3.cout);
        end
        $display("op 011+101 with ignored starts sum=%b cout=%b dones=%0d", bus3.sum, bus3.cout, done_cnt);
    endtask

    task automatic test_back_to_back();
        bus3.start = 1'b1; bus3.a = 3'b001; bus3.b = 3'b001;
        tick();
        for (int j = 0; j <= 14; j++) begin
            checks++;
            if (bus3.busy !== ((j % 5) != 4) || bus3.done !== ((j % 5) == 3)) begin
                failures++;
                $display("FAIL b2b_hs j=%0d busy=%b done=%b required busy=%b done=%b",
                         j, bus3.busy, bus3.done, ((j % 5) != 4), ((j % 5) == 3));
            end
            if ((j % 5) == 3) begin
                checks++;
                if (bus3.sum !== 3'b010 || bus3.cout !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result j=%0d sum=%b cout=%b required 010/0", j, bus3.sum, bus3.cout);
                end
                $display("op 001+001 (held start) sum=%b cout=%b", bus3.sum, bus3.cout);
            end
            if (j < 14) tick();
        end
        bus3.start = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        bus3.start = 1'b1; bus3.a = 3'b011; bus3.b = 3'b101;
        tick();
        bus3.start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus3.busy !== 1'b0 || bus3.done !== 1'b0 || bus3.sum !== 3'b000 || bus3.cout !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear busy=%b done=%b sum=%b cout=%b required 0/0/000/0",
                     bus3.busy, bus3.done, bus3.sum, bus3.cout);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (bus3.busy !== 1'b0 || bus3.done !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet j=%0d busy=%b done=%b required 0/0", j, bus3.busy, bus3.done);
            end
        end
        rst_n = 1'b1;
        $display("reset asserted mid-shift and released");
        bus3.start = 1'b1; bus3.a = 3'b010; bus3.b = 3'b100;
        tick();
        bus3.start = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            checks++;
            if (bus3.busy !== (j < 4) || bus3.done !== (j == 3)) begin
                failures++;
                $display("FAIL postreset_hs j=%0d busy=%b done=%b required busy=%b done=%b",
                         j, bus3.busy, bus3.done, (j < 4), (j == 3));
            end
            if (j == 3) begin
                checks++;
                if (bus3.sum !== 3'b110 || bus3.cout !== 1'b0) begin
                    failures++;
                    $display("FAIL postreset_result sum=%b cout=%b required 110/0", bus3.sum, bus3.cout);
                end
                $display("op 010+100 sum=%b cout=%b", bus3.sum, bus3.cout);
            end
            if (j < 4) tick();
        end
    endtask

    task automatic test_width8();
        int found;
        found = -1;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01;
        tick();
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
        for (int j = 0; j <= 20; j++) begin
            if (bus8.done === 1'b1) begin
                found = j;
                break;
            end
            tick();
        end
        checks++;
        if (found != 8) begin
            failures++;
            $display("FAIL w8_latency latency=%0d required 9 (0 means no done seen)", found + 1);
        end
        checks++;
        if (bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
            failures++;
            $display("FAIL w8_result sum=%h cout=%b required 00/1", bus8.sum, bus8.cout);
        end
        $display("op w8 FF+01 sum=%h cout=%b latency=%0d", bus8.sum, bus8.cout, found + 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_sequential();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_shift();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
